aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_cu_pkg.sv | 40 ++++
 rtl/aes_round_cnt.sv | 39 +++
 rtl/aes_round_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_cu_pkg.sv
// rtl/aes_cu_pkg.sv - shared types, select encodings and round-count helper for the AES round controller
package aes_cu_pkg;

  // Controller states; E* walk the encrypt schedule, D* the decrypt schedule
  typedef enum logic [3:0] {
    ST_WAIT_KEY = 4'd0,
    ST_LOAD     = 4'd1,
    ST_E0       = 4'd2,
    ST_EX       = 4'd3,
    ST_EN       = 4'd4,
    ST_D0       = 4'd5,
    ST_DX       = 4'd6,
    ST_DN       = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  // Round-stage source select feeding the state register
  localparam logic [1:0] RS_ARK = 2'd0;
  localparam logic [1:0] RS_BS  = 2'd1;
  localparam logic [1:0] RS_MC  = 2'd2;

  // Default round counts per key length
  localparam int NR_128_DEF = 10;
  localparam int NR_192_DEF = 12;
  localparam int NR_256_DEF = 14;

  // KL code to round count: 01 -> 128-bit, 00 -> 192-bit, 1x -> 256-bit
  function automatic int nr_of(input logic [1:0] kl,
                               input int n128 = NR_128_DEF,
                               input int n192 = NR_192_DEF,
                               input int n256 = NR_256_DEF);
    if (kl[1])
      return n256;
    else if (kl[0])
      return n128;
    else
      return n192;
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// rtl/aes_round_cnt.sv - round counter with last-round compare and round-key index mapping
module aes_round_cnt #(
  parameter int RCNT_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_map_en,
  input  logic              i_down,
  input  logic [RCNT_W-1:0] i_nr,
  output logic              o_eq_last,
  output logic [RCNT_W-1:0] o_rk_idx
);

  logic [RCNT_W-1:0] r_cnt;
  logic [RCNT_W-1:0] w_nr_m1;

  // Round counter: cleared when a block starts (or is abandoned), steps once per round
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + 1'b1;
  end

  assign w_nr_m1   = i_nr - 1'b1;
  assign o_eq_last = (r_cnt == w_nr_m1);

  // Encrypt walks keys upward from 0, decrypt walks them downward from Nr
  always_comb begin
    o_rk_idx = '0;
    if (i_map_en)
      o_rk_idx = i_down ? (i_nr - r_cnt) : r_cnt;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencing FSM; optional abort input under AES_CU_ABORT_EN
module aes_round_ctrl
  import aes_cu_pkg::*;
#(
  parameter int RCNT_W = 4,
  parameter int NR_128 = NR_128_DEF,
  parameter int NR_192 = NR_192_DEF,
  parameter int NR_256 = NR_256_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              enc_dec,
  input  logic [1:0]        KL,
  input  logic              KF,
  input  logic              in_valid,
`ifdef AES_CU_ABORT_EN
  input  logic              abort,
`endif
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              SE,
  output logic              SCLR,
  output logic              sel_in,
  output logic              sel_bs,
  output logic              sel_mc,
  output logic              sel_ark,
  output logic              sel_st,
  output logic              sel_fin,
  output logic [1:0]        sel_rs,
  output logic [RCNT_W-1:0] rk_idx,
  output logic              busy
);

  state_t            r_state;
  logic [RCNT_W-1:0] r_nr;
  logic              r_enc;

  logic w_accept;
  logic w_abort;
  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_eq_last;

  assign w_accept = (r_state == ST_LOAD) && KF && in_valid;

`ifdef AES_CU_ABORT_EN
  assign w_abort = abort && (r_state != ST_WAIT_KEY);
`else
  assign w_abort = 1'b0;
`endif

  assign w_cnt_en  = (r_state == ST_E0) || (r_state == ST_EX) ||
                     (r_state == ST_D0) || (r_state == ST_DX);
  assign w_cnt_clr = w_accept || w_abort;

  // Round count and direction are frozen at accept so later KL/enc_dec changes are ignored
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_nr  <= RCNT_W'(NR_128);
      r_enc <= 1'b1;
    end else if (w_accept) begin
      r_nr  <= RCNT_W'(nr_of(KL, NR_128, NR_192, NR_256));
      r_enc <= enc_dec;
    end
  end

  // State sequencing; KF is only looked at outside the round states
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_WAIT_KEY;
    end else if (w_abort) begin
      r_state <= ST_WAIT_KEY;
    end else begin
      case (r_state)
        ST_WAIT_KEY: if (KF) r_state <= ST_LOAD;
        ST_LOAD: begin
          if (!KF)
            r_state <= ST_WAIT_KEY;
          else if (in_valid)
            r_state <= enc_dec ? ST_E0 : ST_D0;
        end
        ST_E0:   r_state <= ST_EX;
        ST_EX:   if (w_eq_last) r_state <= ST_EN;
        ST_EN:   r_state <= ST_DONE;
        ST_D0:   r_state <= ST_DX;
        ST_DX:   if (w_eq_last) r_state <= ST_DN;
        ST_DN:   r_state <= ST_DONE;
        ST_DONE: if (out_ready) r_state <= KF ? ST_LOAD : ST_WAIT_KEY;
        default: r_state <= ST_WAIT_KEY;
      endcase
    end
  end

  aes_round_cnt #(
    .RCNT_W (RCNT_W)
  ) u_cnt (
    .i_clk     (CLK),
    .i_rst     (CLR),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .i_map_en  (busy),
    .i_down    (~r_enc),
    .i_nr      (r_nr),
    .o_eq_last (w_eq_last),
    .o_rk_idx  (rk_idx)
  );

  // Moore decode of datapath selects, register control and handshakes
  always_comb begin
    sel_in    = 1'b0;
    sel_bs    = 1'b1;
    sel_rs    = RS_BS;
    sel_mc    = 1'b1;
    sel_ark   = 1'b0;
    sel_st    = 1'b1;
    sel_fin   = 1'b0;
    SE        = 1'b1;
    SCLR      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_WAIT_KEY: begin
        SE   = 1'b0;
        SCLR = 1'b1;
      end
      ST_LOAD: begin
        sel_in   = 1'b1;
        in_ready = KF;
      end
      ST_E0: begin
        sel_bs  = 1'b0;
        sel_rs  = RS_ARK;
        sel_mc  = 1'b0;
        sel_ark = 1'b1;
        busy    = 1'b1;
      end
      ST_EX: begin
        busy = 1'b1;
      end
      ST_EN: begin
        sel_fin = 1'b1;
        busy    = 1'b1;
      end
      ST_D0: begin
        sel_bs  = 1'b0;
        sel_rs  = RS_ARK;
        sel_mc  = 1'b0;
        sel_ark = 1'b1;
        sel_st  = 1'b0;
        busy    = 1'b1;
      end
      ST_DX: begin
        sel_bs  = 1'b0;
        sel_rs  = RS_MC;
        sel_mc  = 1'b0;
        sel_ark = 1'b1;
        sel_st  = 1'b0;
        busy    = 1'b1;
      end
      ST_DN: begin
        sel_bs  = 1'b0;
        sel_rs  = RS_MC;
        sel_mc  = 1'b0;
        sel_ark = 1'b1;
        busy    = 1'b1;
      end
      ST_DONE: begin
        SE        = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        SE   = 1'b0;
        SCLR = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl
module tb_aes_round_ctrl;

  localparam int RCNT_W = 4;

  logic              CLK = 1'b0;
  logic              CLR;
  logic              enc_dec;
  logic [1:0]        KL;
  logic              KF;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              SE;
  logic              SCLR;
  logic              sel_in, sel_bs, sel_mc, sel_ark, sel_st, sel_fin;
  logic [1:0]        sel_rs;
  logic [RCNT_W-1:0] rk_idx;
  logic              busy;
`ifdef AES_CU_ABORT_EN
  logic              abort;
`endif

  aes_round_ctrl #(.RCNT_W(RCNT_W)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .enc_dec   (enc_dec),
    .KL        (KL),
    .KF        (KF),
    .in_valid  (in_valid),
`ifdef AES_CU_ABORT_EN
    .abort     (abort),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SE        (SE),
    .SCLR      (SCLR),
    .sel_in    (sel_in),
    .sel_bs    (sel_bs),
    .sel_mc    (sel_mc),
    .sel_ark   (sel_ark),
    .sel_st    (sel_st),
    .sel_fin   (sel_fin),
    .sel_rs    (sel_rs),
    .rk_idx    (rk_idx),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int rk;
    int rs;
    int fin;
  } step_t;

  step_t exp_q[$];
  int    lat_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tb_nr(input logic [1:0] kl);
    if (kl == 2'b01) return 10;
    if (kl == 2'b00) return 12;
    return 14;
  endfunction

  // Expected per-round key index, stage select, final flag and latency for one block
  task automatic push_block(input logic [1:0] kl, input logic enc);
    int    nr;
    step_t s;
    nr = tb_nr(kl);
    for (int i = 0; i <= nr; i++) begin
      s.rk  = enc ? i : nr - i;
      s.rs  = (i == 0) ? 0 : (enc ? 1 : 2);
      s.fin = (enc && i == nr) ? 1 : 0;
      exp_q.push_back(s);
    end
    lat_q.push_back(nr + 2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclr"}, SCLR, 1);
    check({tag, "_se"}, SE, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rk_idx"}, rk_idx, 0);
    check({tag, "_sels"}, {sel_in, sel_bs, sel_rs, sel_mc, sel_ark, sel_st, sel_fin},
          {1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  // Accept one block from LOAD and score every round cycle until out_valid; returns in DONE
  task automatic run_block(input logic [1:0] kl, input logic enc, input int kf_drop_at);
    int    c;
    bit    done;
    step_t s;
    check("in_ready_load", in_ready, 1);
    KL       = kl;
    enc_dec  = enc;
    in_valid = 1'b1;
    push_block(kl, enc);
    @(negedge CLK);
    in_valid = 1'b0;
    KL       = ~kl;
    enc_dec  = ~enc;
    c    = 1;
    done = 0;
    while (!done && c < 40) begin
      if (kf_drop_at == c) KF = 1'b0;
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("rk_extra_round", 1, 0);
        end else begin
          s = exp_q.pop_front();
          check("rk_idx", rk_idx, s.rk);
          check("sel_rs", sel_rs, s.rs);
          check("sel_fin", sel_fin, s.fin);
          check("se_busy", SE, 1);
        end
      end else if (out_valid) begin
        check("latency", c, (lat_q.size() != 0) ? lat_q.pop_front() : -1);
        done = 1;
      end else begin
        check("busy_dropped", busy, 1);
        done = 1;
      end
      if (!done) begin
        @(negedge CLK);
        c++;
      end
    end
    if (!done) check("out_valid_timeout", 0, 1);
    check("rounds_left", exp_q.size(), 0);
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    CLR       = 1'b1;
    KF        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    KL        = 2'b01;
    enc_dec   = 1'b1;
`ifdef AES_CU_ABORT_EN
    abort     = 1'b0;
`endif
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    check("wait_key_sclr", SCLR, 1);
    check("wait_key_in_ready", in_ready, 0);
    KF = 1'b1;
    @(negedge CLK);
    check("load_se", SE, 1);
    check("load_sel_in", sel_in, 1);
    check("load_sclr", SCLR, 0);

    // KL=01 encrypt, then hold the result for 5 cycles and go back-to-back
    run_block(2'b01, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_se", SE, 0);
      check("hold_in_ready", in_ready, 0);
      @(negedge CLK);
    end
    release_done();
    check("b2b_load", in_ready, 1);
    check("b2b_out_valid", out_valid, 0);

    // KL=10 decrypt
    run_block(2'b10, 1'b0, 0);
    release_done();
    check("dec_to_load", in_ready, 1);

    // KL=00 encrypt with KF dropped mid-block
    run_block(2'b00, 1'b1, 4);
    release_done();
    check("kf_drop_sclr", SCLR, 1);
    check("kf_drop_in_ready", in_ready, 0);
    check("kf_drop_se", SE, 0);
    KF = 1'b1;
    @(negedge CLK);

    // A few random blocks
    for (int n = 0; n < 4; n++) begin
      run_block(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
      release_done();
    end

    // CLR in the middle of EX
    check("clr_pre_load", in_ready, 1);
    KL       = 2'b01;
    enc_dec  = 1'b1;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("clr_pre_busy", busy, 1);
    #2 CLR = 1'b1;
    #1;
    check_reset_outputs("clr_mid");
    @(negedge CLK);
    CLR  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    check("clr_no_out_valid", seen, 0);

`ifdef AES_CU_ABORT_EN
    // Abort while in DX
    check("abort_pre_load", in_ready, 1);
    KL       = 2'b10;
    enc_dec  = 1'b0;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("abort_in_dx", sel_rs, 2);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_sclr", SCLR, 1);
    check("abort_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
